// File: rtl/hazard_scoreboard.sv
// D-stage hazard unit with an internal shift-register scoreboard of in-flight writers.
// Produces the stall, D/E forwarding selects, the MDU busy interlock and the eret/EPC interlock.
module hazard_scoreboard #(
  parameter int DEPTH     = 3,
  parameter int AW        = 5,
  parameter int TW        = 2,
  parameter int SW        = 2,
  parameter int MULT_LAT  = 5,
  parameter int DIV_LAT   = 10,
  parameter int EPC_ADDR  = 14,
  parameter int EPC_SLOTS = 2,
  parameter int SCW       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_valid,
  input  logic [AW-1:0]    d_ra1,
  input  logic [AW-1:0]    d_ra2,
  input  logic [TW-1:0]    d_tuse_rs,
  input  logic [TW-1:0]    d_tuse_rt,
  input  logic             d_we,
  input  logic [AW-1:0]    d_wa,
  input  logic [TW-1:0]    d_tnew,
  input  logic             d_md_start,
  input  logic             d_is_div,
  input  logic             d_md_use,
  input  logic             d_mtc0_epc,
  input  logic             d_eret,
  input  logic             flush_d,
  input  logic [DEPTH-1:0] flush_mask,
  input  logic [AW-1:0]    e_ra1,
  input  logic [AW-1:0]    e_ra2,
  output logic             stall,
  output logic [SW-1:0]    fwd_rs_d,
  output logic [SW-1:0]    fwd_rt_d,
  output logic [SW-1:0]    fwd_rs_e,
  output logic [SW-1:0]    fwd_rt_e,
  output logic             md_busy,
  output logic [SCW-1:0]   stall_cnt
);

  localparam int CW = $clog2(DIV_LAT + 2);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] wa;
    logic [TW-1:0] rem;
    logic          md;
    logic          epc;
  } slot_t;

  typedef struct packed {
    logic [SW-1:0] idx;
    logic [TW-1:0] rem;
  } hit_t;

  slot_t slot_reg  [1:DEPTH];
  slot_t slot_next [1:DEPTH];

  logic [CW-1:0] md_cnt_reg;
  logic [CW-1:0] md_load_reg;
  logic [CW-1:0] md_load;
  logic          issue;
  logic          stall_rs;
  logic          stall_rt;
  logic          md_stall;
  logic          eret_any;
  logic          eret_stall;
  hit_t          hit_rs_d;
  hit_t          hit_rt_d;
  hit_t          hit_rs_e;
  hit_t          hit_rt_e;

  // Lowest-index (youngest) valid slot at or above lo writing address a; idx 0 means no match.
  function automatic hit_t youngest(input logic [AW-1:0] a, input int lo);
    hit_t h;
    h = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (k >= lo && slot_reg[k].valid && slot_reg[k].wa == a && a != '0) begin
        h.idx = SW'(k);
        h.rem = slot_reg[k].rem;
      end
    end
    return h;
  endfunction

  assign md_busy = (md_cnt_reg != '0);
  assign md_load = d_is_div ? CW'(DIV_LAT + 1) : CW'(MULT_LAT + 1);

  always_comb begin
    hit_rs_d = youngest(d_ra1, 1);
    hit_rt_d = youngest(d_ra2, 1);
    hit_rs_e = youngest(e_ra1, 2);
    hit_rt_e = youngest(e_ra2, 2);

    // A miss reports rem 0, so it can neither stall nor forward.
    stall_rs = hit_rs_d.rem > d_tuse_rs;
    stall_rt = hit_rt_d.rem > d_tuse_rt;
    fwd_rs_d = (hit_rs_d.rem == '0) ? hit_rs_d.idx : '0;
    fwd_rt_d = (hit_rt_d.rem == '0) ? hit_rt_d.idx : '0;
    fwd_rs_e = (hit_rs_e.rem == '0) ? hit_rs_e.idx : '0;
    fwd_rt_e = (hit_rt_e.rem == '0) ? hit_rt_e.idx : '0;

    eret_any = 1'b0;
    for (int k = 1; k <= EPC_SLOTS; k++) begin
      if (slot_reg[k].valid && slot_reg[k].epc) eret_any = 1'b1;
    end
    eret_stall = d_eret && eret_any;
    md_stall   = d_md_use && md_busy;

    stall = d_valid && !flush_d && (stall_rs || stall_rt || md_stall || eret_stall);
    issue = d_valid && !stall && !flush_d;
  end

  always_comb begin
    slot_next[1] = '0;
    if (issue) begin
      slot_next[1].valid = 1'b1;
      slot_next[1].wa    = d_we ? d_wa : '0;
      slot_next[1].rem   = d_tnew;
      slot_next[1].md    = d_md_start;
      slot_next[1].epc   = d_mtc0_epc;
    end
    for (int k = 2; k <= DEPTH; k++) begin
      slot_next[k] = slot_reg[k-1];
      if (slot_reg[k-1].rem != '0) slot_next[k].rem = slot_reg[k-1].rem - TW'(1);
      if (flush_mask[k-2]) slot_next[k] = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 1; k <= DEPTH; k++) slot_reg[k] <= '0;
    end else begin
      for (int k = 1; k <= DEPTH; k++) slot_reg[k] <= slot_next[k];
    end
  end

  // The +1 in the load value covers the E cycle; a mult/div killed in E cancels its count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt_reg  <= '0;
      md_load_reg <= '0;
    end else if (issue && d_md_start) begin
      md_cnt_reg  <= md_load;
      md_load_reg <= md_load;
    end else if (flush_mask[0] && slot_reg[1].valid && slot_reg[1].md && md_cnt_reg == md_load_reg) begin
      md_cnt_reg <= '0;
    end else if (md_cnt_reg != '0) begin
      md_cnt_reg <= md_cnt_reg - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + SCW'(1);
    end
  end

  // The oldest slot has no successor to flush, and EPC decoding happens upstream.
  logic unused_bits;
  assign unused_bits = ^{flush_mask[DEPTH-1], AW'(EPC_ADDR)};

endmodule
